// File: rtl/pir_condicionador.sv
// Conditions the raw PIR line into a stable occupancy flag: 2-flop synchroniser,
// debounce qualification, then a retriggerable hold timeout after motion stops.
module pir_condicionador #(
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int HOLD_CYCLES     = 720_000_000,
    parameter int CNT_W           = $clog2((DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                                           DEBOUNCE_CYCLES : HOLD_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pir_in,
    output logic       ocupado,
    output logic       entrada_pulso,
    output logic       saida_pulso,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        VAZIO       = 2'd0,
        CONFIRMANDO = 2'd1,
        OCUPADO     = 2'd2,
        ESPERA      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s1, pir_s;
    logic             ocupado_n, entrada_n, saida_n;

    // Only pir_s feeds the FSM; s1 may be metastable and is never decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            pir_s <= 1'b0;
        end else begin
            s1    <= pir_in;
            pir_s <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= VAZIO;
            cnt           <= '0;
            ocupado       <= 1'b0;
            entrada_pulso <= 1'b0;
            saida_pulso   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            ocupado       <= ocupado_n;
            entrada_pulso <= entrada_n;
            saida_pulso   <= saida_n;
        end
    end

    // The counter is zeroed on every transition, so each state starts counting fresh.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ocupado_n = ocupado;
        entrada_n = 1'b0;
        saida_n   = 1'b0;
        case (state)
            VAZIO: begin
                if (pir_s) begin
                    state_n = CONFIRMANDO;
                    cnt_n   = '0;
                end
            end
            CONFIRMANDO: begin
                if (!pir_s) begin
                    state_n = VAZIO;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = OCUPADO;
                    cnt_n     = '0;
                    ocupado_n = 1'b1;
                    entrada_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            OCUPADO: begin
                if (!pir_s) begin
                    state_n = ESPERA;
                    cnt_n   = '0;
                end
            end
            ESPERA: begin
                // Motion during the hold wins, even on the very last hold cycle.
                if (pir_s) begin
                    state_n = OCUPADO;
                    cnt_n   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_n   = VAZIO;
                    cnt_n     = '0;
                    ocupado_n = 1'b0;
                    saida_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n   = VAZIO;
                cnt_n     = '0;
                ocupado_n = 1'b0;
            end
        endcase
    end

    assign estado = state;

endmodule

// File: tb/tb_pir_condicionador.sv
// Bench for pir_condicionador: run-length occupancy model feeds an expected
// queue each clock; a negedge monitor pops and compares against the outputs.
module tb_pir_condicionador;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pir_in = 1'b1;
    logic       ocupado, entrada_pulso, saida_pulso;
    logic [1:0] estado;

    int tests = 0;
    int fails = 0;

    logic [4:0] exp_q[$];

    pir_condicionador #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pir_in       (pir_in),
        .ocupado      (ocupado),
        .entrada_pulso(entrada_pulso),
        .saida_pulso  (saida_pulso),
        .estado       (estado)
    );

    // clock
    always #5 clk = ~clk;

    // Reference model: occupancy follows run lengths of the two-edge-delayed PIR.
    logic       m_s1 = 1'b0, m_ps = 1'b0;
    logic       m_occ = 1'b0;
    int         m_high = 0, m_low = 0;

    always @(posedge clk) begin
        logic       ein, sout;
        logic [1:0] est;
        ein  = 1'b0;
        sout = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_ps = 1'b0; m_occ = 1'b0; m_high = 0; m_low = 0;
        end else begin
            if (!m_occ) begin
                if (m_ps) begin
                    m_high++;
                    if (m_high == DEB + 1) begin
                        m_occ = 1'b1; ein = 1'b1; m_high = 0; m_low = 0;
                    end
                end else begin
                    m_high = 0;
                end
            end else begin
                if (!m_ps) begin
                    m_low++;
                    if (m_low == HOLD + 1) begin
                        m_occ = 1'b0; sout = 1'b1; m_low = 0; m_high = 0;
                    end
                end else begin
                    m_low = 0;
                end
            end
            m_ps = m_s1;
            m_s1 = pir_in;
        end
        if (m_occ) est = (m_low == 0) ? 2'd2 : 2'd3;
        else       est = (m_high == 0) ? 2'd0 : 2'd1;
        exp_q.push_back({m_occ, ein, sout, est});
    end

    // monitor
    always @(negedge clk) begin
        logic [4:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {ocupado, entrada_pulso, saida_pulso, estado};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs t=%0t got ocup=%b ent=%b sai=%b est=%0d expected ocup=%b ent=%b sai=%b est=%0d",
                         $time, act_v[4], act_v[3], act_v[2], act_v[1:0],
                         exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    task automatic step(input logic r, input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = r;
            pir_in = p;
        end
    endtask

    initial begin
        // 1: reset held with pir high, then release and qualify
        step(1, 1, 3);
        step(0, 1, 12);
        // 4: fall and full timeout
        step(0, 0, 15);
        // 2: short glitch discarded
        step(0, 1, 3);
        step(0, 0, 5);
        // 3: rise and hold
        step(0, 1, 10);
        // 5: retrigger mid-hold at cnt=5
        step(0, 0, 6);
        step(0, 1, 1);
        step(0, 0, 15);
        // retrigger on the final hold cycle
        step(0, 1, 8);
        step(0, 0, 10);
        step(0, 1, 1);
        step(0, 0, 4);
        // 6: reset while holding at cnt=7
        step(0, 1, 8);
        step(0, 0, 10);
        step(1, 0, 1);
        step(0, 0, 3);
        // randomized run lengths with occasional resets
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 29) == 0)
                step(1, 1'($urandom_range(0, 1)), 1);
            else
                step(0, 1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pir_condicionador.md
# pir_condicionador

Conditions the raw PIR sensor line into a stable occupancy flag for the room-occupancy design. Synchronises the asynchronous `pir_in`, rejects short glitches with a debounce counter, and holds occupancy for a retriggerable timeout after motion stops. It sits directly upstream of the occupancy consumer (`led_rgb`): its `ocupado` output drives that module's `ocupado` input.

## Interface
- `DEBOUNCE_CYCLES`, 120_000: consecutive synchronised-high cycles required to declare occupancy (10 ms at 12 MHz); must be ≥1.
- `HOLD_CYCLES`, 720_000_000: cycles occupancy is held after the synchronised PIR goes low (60 s at 12 MHz); must be ≥1.
- `CNT_W`, `$clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES))+1`: shared counter width.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pir_in`  in  1  raw PIR output, asynchronous to `clk`.
- `ocupado`  out  1  registered occupancy flag.
- `entrada_pulso`  out  1  one-cycle pulse when `ocupado` rises.
- `saida_pulso`  out  1  one-cycle pulse when `ocupado` falls by timeout.
- `estado`  out  2  current FSM state, for debug.

## Operation
- 2-flop synchroniser: `pir_in` → `s1` → `pir_s`. No logic reads `s1` or `pir_in` directly.
- One shared counter `cnt` (CNT_W bits). It is cleared on every state entry and never wraps.
- FSM states, with `estado` encoding:
  - VAZIO = 0: `pir_s=1` → CONFIRMANDO, `cnt←0`.
  - CONFIRMANDO = 1:
    - `pir_s=0` → VAZIO. The glitch is discarded and no pulse is emitted.
    - Else, if `cnt==DEBOUNCE_CYCLES-1` → OCUPADO, `ocupado←1`, `entrada_pulso←1`.
    - Else `cnt←cnt+1`.
  - OCUPADO = 2: `pir_s=0` → ESPERA, `cnt←0`.
  - ESPERA = 3:
    - `pir_s=1` → OCUPADO. Immediate retrigger with no debounce and no pulse.
    - Else, if `cnt==HOLD_CYCLES-1` → VAZIO, `ocupado←0`, `saida_pulso←1`.
    - Else `cnt←cnt+1`.
- `ocupado` = 1 exactly in OCUPADO and ESPERA. It is a flop updated on the same edge as the state, not a combinational decode.
- Each pulse is high for exactly one cycle and then cleared. The two pulses are never high together.

## Timing
- Reset (`rst=1` at an edge): state VAZIO, `cnt=0`, `s1=pir_s=0`, `ocupado=0`, `entrada_pulso=0`, `saida_pulso=0`, `estado=0`.
  - Reset overrides all transitions, including mid-CONFIRMANDO and mid-ESPERA.
  - No `saida_pulso` is generated by reset.
  - The value of `pir_in` during reset is ignored.
- Rising path:
  - `pir_in` high sampled at edge k gives `pir_s=1` after edge k+1.
  - CONFIRMANDO after edge k+2.
  - `ocupado=1` and `entrada_pulso=1` after edge k+2+DEBOUNCE_CYCLES, provided `pir_in` stays high.
- Falling path:
  - `pir_in` low sampled at edge m gives ESPERA after edge m+2.
  - `ocupado=0` and `saida_pulso=1` after edge m+2+HOLD_CYCLES, provided no retrigger.
- Debounce: any low `pir_s` in CONFIRMANDO restarts qualification from VAZIO. A high `pir_s` at the next edge re-enters CONFIRMANDO with `cnt=0`.
- Retrigger on the final ESPERA cycle (`pir_s=1` while `cnt==HOLD_CYCLES-1`): retrigger wins. The FSM goes to OCUPADO, `ocupado` stays 1, no pulse.
- DEBOUNCE_CYCLES=1: occupancy is declared one edge after CONFIRMANDO entry. HOLD_CYCLES=1 behaves the same way for the hold.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
1. Hold `rst=1` for 3 cycles with `pir_in=1` → all outputs 0 and `estado=0` throughout. Release at edge r: `ocupado=1` after edge r+6, with one `entrada_pulso`.
2. `pir_in` high for 3 cycles, then low → `estado` visits 1 then returns to 0. `ocupado` and both pulses stay 0.
3. `pir_in` rises at edge k and holds → `ocupado` and `entrada_pulso` both 1 after edge k+6. `entrada_pulso` is 0 after edge k+7.
4. From OCUPADO, `pir_in` falls at edge m → `estado=3` after m+2. `ocupado=0` with a single `saida_pulso` after m+12.
5. In ESPERA at `cnt=5`, pulse `pir_in` high for 1 cycle → `estado` goes 3→2→3 and `ocupado` never drops. No pulses. The new timeout restarts from the later fall.
6. Assert `rst` while `estado=3` at `cnt=7` → after that edge `ocupado=0`, `estado=0`, `saida_pulso=0`.
